// File: rtl/motor_drive_sequencer.sv
// H-bridge command sequencer: auto/manual arbitration, shoot-through rejection, reversal dead time, PWM gate.
// Optional manual-source watchdog is compiled in with `define MOTOR_SEQ_WDOG_EN.
module motor_drive_sequencer #(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned DEAD_CYCLES = 16,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          auto_cmd_i,
  input  logic                auto_valid_i,
  input  logic [3:0]          man_cmd_i,
  input  logic                man_valid_i,
  input  logic                man_sel_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic [3:0]          motors_o,
  output logic                grant_man_o,
  output logic                busy_o,
  output logic                fault_o,
  output logic                wdog_to_o
);

  localparam int unsigned DeadW = $clog2(DEAD_CYCLES + 1);
  localparam logic [DeadW-1:0] DeadLoad = DeadW'(DEAD_CYCLES);
  localparam logic [DeadW-1:0] DeadOne  = DeadW'(1);

  if (DEAD_CYCLES < 1) begin : g_bad_dead
    $error("DEAD_CYCLES must be at least 1");
  end
  if (WDOG_CYCLES < 2) begin : g_bad_wdog
    $error("WDOG_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } state_e;

  // A pair with both legs on would short the supply; drop that motor to coast.
  function automatic logic [1:0] sanitise_pair(input logic [1:0] pair);
    return (pair == 2'b11) ? 2'b00 : pair;
  endfunction

  function automatic logic is_reversal(input logic [1:0] cur, input logic [1:0] nxt);
    return ((cur == 2'b10) && (nxt == 2'b01)) || ((cur == 2'b01) && (nxt == 2'b10));
  endfunction

  state_e              state_q;
  logic [3:0]          applied_q;
  logic [3:0]          pending_q;
  logic [DeadW-1:0]    dead_cnt_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [3:0]          motors_q;
  logic                grant_man_q;
  logic                busy_q;
  logic                fault_q;

  logic                switch_s;
  logic                wdog_fire_s;
  logic [3:0]          raw_cmd_s;
  logic                raw_valid_s;
  logic                accept_s;
  logic [3:0]          cmd_s;
  logic                bad_s;
  logic                reversal_s;
  logic [3:0]          pending_d;

  // Pick the command accepted this cycle: source switch, then watchdog, then selected strobe.
  always_comb begin
    switch_s    = (man_sel_i != grant_man_q);
    raw_cmd_s   = 4'b0000;
    raw_valid_s = 1'b0;
    accept_s    = 1'b0;
    cmd_s       = 4'b0000;
    bad_s       = 1'b0;
    if (grant_man_q) begin
      raw_cmd_s   = man_cmd_i;
      raw_valid_s = man_valid_i;
    end else begin
      raw_cmd_s   = auto_cmd_i;
      raw_valid_s = auto_valid_i;
    end
    if (switch_s || wdog_fire_s) begin
      accept_s = 1'b1;
    end else if (raw_valid_s) begin
      accept_s = 1'b1;
      cmd_s    = {sanitise_pair(raw_cmd_s[3:2]), sanitise_pair(raw_cmd_s[1:0])};
      bad_s    = (raw_cmd_s[3:2] == 2'b11) || (raw_cmd_s[1:0] == 2'b11);
    end else begin
      accept_s = 1'b0;
    end
    reversal_s = is_reversal(applied_q[3:2], cmd_s[3:2]) |
                 is_reversal(applied_q[1:0], cmd_s[1:0]);
    pending_d  = accept_s ? cmd_s : pending_q;
  end

  // Sequencer FSM with registered bridge drive, PWM counter and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      applied_q   <= 4'b0000;
      pending_q   <= 4'b0000;
      dead_cnt_q  <= '0;
      pwm_cnt_q   <= '0;
      motors_q    <= 4'b0000;
      grant_man_q <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      pwm_cnt_q   <= pwm_cnt_q + PWM_BITS'(1);
      grant_man_q <= man_sel_i;
      motors_q    <= applied_q & {4{pwm_cnt_q < duty_i}};
      busy_q      <= (state_q == S_DEAD);
      if (bad_s) begin
        fault_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (accept_s && (cmd_s != 4'b0000)) begin
            applied_q <= cmd_s;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          if (accept_s) begin
            if (reversal_s) begin
              pending_q  <= cmd_s;
              applied_q  <= 4'b0000;
              dead_cnt_q <= DeadLoad;
              state_q    <= S_DEAD;
            end else begin
              applied_q <= cmd_s;
              state_q   <= (cmd_s == 4'b0000) ? S_IDLE : S_RUN;
            end
          end
        end
        S_DEAD: begin
          // Late commands only retarget the pending command; the off time never restarts.
          if (dead_cnt_q == DeadOne) begin
            applied_q  <= pending_d;
            pending_q  <= 4'b0000;
            dead_cnt_q <= '0;
            state_q    <= (pending_d == 4'b0000) ? S_IDLE : S_RUN;
          end else begin
            pending_q  <= pending_d;
            dead_cnt_q <= dead_cnt_q - DeadOne;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          applied_q <= 4'b0000;
          pending_q <= 4'b0000;
        end
      endcase
    end
  end

`ifdef MOTOR_SEQ_WDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_CYCLES - 1);
  localparam logic [WdogW-1:0] WdogMax  = WdogW'(WDOG_CYCLES);

  logic [WdogW-1:0] wdog_cnt_q;
  logic             wdog_to_q;

  assign wdog_fire_s = grant_man_q & ~switch_s & ~man_valid_i & (wdog_cnt_q == WdogLast);

  // Counts manual-source silence; saturates after firing so the stop is issued once.
  always_ff @(posedge clk) begin
    if (reset || !grant_man_q || switch_s) begin
      wdog_cnt_q <= '0;
      wdog_to_q  <= 1'b0;
    end else if (man_valid_i) begin
      wdog_cnt_q <= '0;
      wdog_to_q  <= 1'b0;
    end else if (wdog_fire_s) begin
      wdog_cnt_q <= WdogMax;
      wdog_to_q  <= 1'b1;
    end else if (wdog_cnt_q != WdogMax) begin
      wdog_cnt_q <= wdog_cnt_q + WdogW'(1);
    end
  end

  assign wdog_to_o = wdog_to_q;
`else
  assign wdog_fire_s = 1'b0;
  assign wdog_to_o   = 1'b0;
`endif

  assign motors_o    = motors_q;
  assign grant_man_o = grant_man_q;
  assign busy_o      = busy_q;
  assign fault_o     = fault_q;

endmodule
